// File: rtl/lab4_vector_checker.sv
// Self-test sequencer for the Lab4 comparator/RGB indicator.
// Walks all 16 {a1,a0,b1,b0} vectors, holds each for HOLD_CYCLES clocks,
// samples r/g/b on the last hold cycle and records error count, first
// failing vector and an overall pass flag.
module lab4_vector_checker #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a1,
  output logic       a0,
  output logic       b1,
  output logic       b0,
  input  logic       r_in,
  input  logic       g_in,
  input  logic       b_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [3:0] idx;
  logic [7:0] hold;

  logic [1:0] op_a, op_b;
  logic [2:0] expected;
  logic       mismatch;
  logic [4:0] err_next;

  // Golden comparator response for the vector currently driven.
  assign op_a     = idx[3:2];
  assign op_b     = idx[1:0];
  assign expected = {op_a > op_b, op_a == op_b, op_a < op_b};
  assign mismatch = ({r_in, g_in, b_in} != expected);
  assign err_next = err_count + {4'd0, mismatch};

  // Sequencer: stimulus, hold timing, sampling and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      idx                 <= '0;
      hold                <= '0;
      {a1, a0, b1, b0}    <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
      err_count           <= '0;
      fail_valid          <= 1'b0;
      fail_vec            <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A start in DONE restarts immediately, same as from IDLE.
          if (start) begin
            state            <= DRIVE;
            idx              <= '0;
            hold             <= '0;
            {a1, a0, b1, b0} <= 4'd0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            fail_valid       <= 1'b0;
            fail_vec         <= '0;
          end
        end
        DRIVE: begin
          // start is deliberately ignored while a run is active.
          hold <= hold + 8'd1;
          if (hold == HOLD_LAST) begin
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
              fail_vec   <= idx;
              fail_valid <= 1'b1;
            end
            if (idx != 4'd15) begin
              idx              <= idx + 4'd1;
              hold             <= '0;
              {a1, a0, b1, b0} <= idx + 4'd1;
            end else begin
              state            <= DONE;
              idx              <= '0;
              hold             <= '0;
              {a1, a0, b1, b0} <= 4'd0;
              busy             <= 1'b0;
              done             <= 1'b1;
              pass             <= (err_next == 5'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab4_vector_checker.sv
// Bench for lab4_vector_checker: two instances (HOLD_CYCLES 4 and 2) driven
// by configurable fake DUTs (golden, r/b swapped, g stuck 0/1, random) with
// an optional 0..3 cycle output lag. A cycle-position model predicts every
// output each cycle; directed runs pin the model with literal results.
module tb_lab4_vector_checker;

  localparam int NI = 2;
  int hc [NI] = '{4, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  wire [NI-1:0][3:0] stim;
  wire [NI-1:0]      busy, done, pass, fvalid;
  wire [NI-1:0][4:0] errc;
  wire [NI-1:0][3:0] fvec;
  logic [NI-1:0][2:0] rgb;

  logic [2:0] raw [NI];
  logic [2:0] d1  [NI];
  logic [2:0] d2  [NI];
  logic [2:0] d3  [NI];
  logic [2:0] rnd [NI];
  int mode [NI];
  int lag  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  lab4_vector_checker #(.HOLD_CYCLES(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start),
    .a1(stim[0][3]), .a0(stim[0][2]), .b1(stim[0][1]), .b0(stim[0][0]),
    .r_in(rgb[0][2]), .g_in(rgb[0][1]), .b_in(rgb[0][0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .fail_valid(fvalid[0]), .fail_vec(fvec[0])
  );

  lab4_vector_checker #(.HOLD_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .a1(stim[1][3]), .a0(stim[1][2]), .b1(stim[1][1]), .b0(stim[1][0]),
    .r_in(rgb[1][2]), .g_in(rgb[1][1]), .b_in(rgb[1][0]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .fail_valid(fvalid[1]), .fail_vec(fvec[1])
  );

  // Comparator truth: {r,g,b} = {A>B, A==B, A<B}.
  function automatic logic [2:0] gold(input logic [3:0] v);
    int a, b;
    a = int'(v[3:2]);
    b = int'(v[1:0]);
    return {a > b, a == b, a < b};
  endfunction

  // Fake device under test with selectable fault.
  function automatic logic [2:0] dut_fn(input logic [3:0] v, input int m, input logic [2:0] r);
    logic [2:0] g;
    g = gold(v);
    case (m)
      1:       return {g[0], g[1], g[2]};
      2:       return {g[2], 1'b0, g[0]};
      3:       return {g[2], 1'b1, g[0]};
      4:       return r;
      default: return g;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      raw[i] = dut_fn(stim[i], mode[i], rnd[i]);
      case (lag[i])
        0:       rgb[i] = raw[i];
        1:       rgb[i] = d1[i];
        2:       rgb[i] = d2[i];
        default: rgb[i] = d3[i];
      endcase
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        d1[i] <= '0; d2[i] <= '0; d3[i] <= '0; rnd[i] <= '0;
      end else begin
        d1[i]  <= raw[i];
        d2[i]  <= d1[i];
        d3[i]  <= d2[i];
        rnd[i] <= 3'($urandom);
      end
    end
  end

  // Reference: a run is a position p counted in cycles since the accepted
  // start; vector p/H is on the pins and the last cycle of each hold window
  // is the sample point.
  bit         m_run    [NI];
  bit         m_done   [NI];
  bit         m_fvalid [NI];
  int         m_p      [NI];
  int         m_err    [NI];
  logic [3:0] m_fv     [NI];

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_run[i] = 0; m_done[i] = 0; m_fvalid[i] = 0;
        m_p[i] = 0; m_err[i] = 0; m_fv[i] = '0;
      end else if (start && !m_run[i]) begin
        m_run[i] = 1; m_done[i] = 0; m_fvalid[i] = 0;
        m_p[i] = 0; m_err[i] = 0; m_fv[i] = '0;
      end else if (m_run[i]) begin
        if (m_p[i] % hc[i] == hc[i] - 1) begin
          logic [3:0] v;
          v = 4'(m_p[i] / hc[i]);
          if (rgb[i] !== gold(v)) begin
            m_err[i]++;
            if (!m_fvalid[i]) begin
              m_fvalid[i] = 1;
              m_fv[i] = v;
            end
          end
          if (v == 4'd15) begin
            m_run[i] = 0;
            m_done[i] = 1;
          end
        end
        m_p[i]++;
      end
    end
  end

  // Every cycle: all outputs of both instances against the model.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      logic [16:0] act, exp;
      act = {busy[i], done[i], pass[i], errc[i], fvalid[i], fvec[i], stim[i]};
      exp = {m_run[i], m_done[i], m_done[i] && (m_err[i] == 0), 5'(m_err[i]),
             m_fvalid[i], m_fv[i], m_run[i] ? 4'(m_p[i] / hc[i]) : 4'd0};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL inst%0d outputs {busy,done,pass,err,fvalid,fvec,stim} t=%0t: got %h want %h",
                 i, $time, act, exp);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int n, output int b0, output int b1);
    b0 = 0;
    b1 = 0;
    repeat (n) begin
      b0 += int'(busy[0]);
      b1 += int'(busy[1]);
      step();
    end
  endtask

  task automatic set_cfg(input int m, input int l0, input int l1);
    mode[0] = m; mode[1] = m;
    lag[0] = l0; lag[1] = l1;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s inst%0d all outputs", tag, i),
            int'({busy[i], done[i], pass[i], errc[i], fvalid[i], fvec[i], stim[i]}), 0);
  endtask

  initial begin
    int b0, b1, n;
    set_cfg(0, 0, 1);
    rst = 1'b1;
    step(); step();
    check_reset_state("power-on reset");
    rst = 1'b0;
    step();

    // Golden DUT: 64-cycle run on inst0, 32 on inst1 with a 1-cycle lag.
    pulse_start();
    wait_cyc(70, b0, b1);
    check("golden busy cycles inst0", b0, 64);
    check("golden busy cycles inst1", b1, 32);
    check("golden done inst0", int'(done[0]), 1);
    check("golden pass inst0", int'(pass[0]), 1);
    check("golden err inst0", int'(errc[0]), 0);
    check("golden fvalid inst0", int'(fvalid[0]), 0);
    check("golden lag1 pass inst1", int'(pass[1]), 1);

    // r/b swapped: every A!=B vector fails, first is 0001.
    set_cfg(1, 0, 1);
    pulse_start();
    wait_cyc(70, b0, b1);
    check("swap err inst0", int'(errc[0]), 12);
    check("swap pass inst0", int'(pass[0]), 0);
    check("swap fvalid inst0", int'(fvalid[0]), 1);
    check("swap fvec inst0", int'(fvec[0]), 1);
    check("swap err inst1", int'(errc[1]), 12);

    // g stuck 0: only the four A==B vectors fail.
    set_cfg(2, 0, 1);
    pulse_start();
    wait_cyc(70, b0, b1);
    check("g0 err inst0", int'(errc[0]), 4);
    check("g0 fvec inst0", int'(fvec[0]), 0);

    // g stuck 1: every A!=B vector fails.
    set_cfg(3, 0, 1);
    pulse_start();
    wait_cyc(70, b0, b1);
    check("g1 err inst0", int'(errc[0]), 12);
    check("g1 fvec inst0", int'(fvec[0]), 1);

    // Restart in DONE, ignored start mid-run, reset mid-run, then a clean run.
    set_cfg(0, 0, 2);
    pulse_start();
    check("restart clears err inst0", int'(errc[0]), 0);
    wait_cyc(9, b0, b1);
    pulse_start();
    wait_cyc(9, b0, b1);
    rst = 1'b1;
    step();
    check_reset_state("mid-run reset");
    rst = 1'b0;
    step();
    pulse_start();
    wait_cyc(70, b0, b1);
    check("after reset busy cycles inst0", b0, 64);
    check("after reset pass inst0", int'(pass[0]), 1);
    check("lag2 pass inst1", int'(pass[1]), 0);

    // Randomized faults, lags, start glitches and occasional resets.
    for (int it = 0; it < 40; it++) begin
      mode[0] = $urandom_range(0, 4);
      mode[1] = $urandom_range(0, 4);
      lag[0]  = $urandom_range(0, 3);
      lag[1]  = $urandom_range(0, 2);
      pulse_start();
      n = $urandom_range(10, 90);
      repeat (n) begin
        start = ($urandom_range(0, 7) == 0);
        rst   = ($urandom_range(0, 59) == 0);
        step();
      end
      start = 1'b0;
      rst   = 1'b0;
      step();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lab4_vector_checker.md
Name: lab4_vector_checker

Overview:
- Synthesizable on-chip counterpart to the Lab4 comparator/RGB-indicator logic.
- Drives all 16 input combinations {a1,a0,b1,b0} into the device under test and samples its r/g/b outputs after a settle window.
- Checks each sample against the golden comparator function, then reports pass/fail, error count and the first failing vector.
- Sits beside the Lab4 instance on the board: switches/LEDs are replaced by this self-test sequencer.

Parameters:
- HOLD_CYCLES, 4, clock cycles each vector is held before sampling; legal range 2..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a full 16-vector run.
- a1  output  1  stimulus, operand A bit 1.
- a0  output  1  stimulus, operand A bit 0.
- b1  output  1  stimulus, operand B bit 1.
- b0  output  1  stimulus, operand B bit 0.
- r_in  input  1  device-under-test r output.
- g_in  input  1  device-under-test g output.
- b_in  input  1  device-under-test b output.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 means err_count==0.
- err_count  output  5  number of mismatching vectors, 0..16.
- fail_valid  output  1  at least one mismatch recorded in this run.
- fail_vec  output  4  {a1,a0,b1,b0} of the first mismatching vector.

Behaviour:
- Golden function, with A={a1,a0} and B={b1,b0} unsigned:
  - r = (A>B)
  - g = (A==B)
  - b = (A<B)
  - Exactly one bit is expected high; any other pattern is a mismatch.
- Reset values (synchronous, on any clock edge with rst=1, including mid-run):
  - State IDLE; a1=a0=b1=b0=0.
  - busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0.
  - Vector index and hold counter cleared.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - Stimulus outputs are 0.
  - When start=1: go to DRIVE with idx=0 and hold=0. In the same edge, clear done, pass, err_count, fail_valid and fail_vec, and set busy=1.
- DRIVE:
  - Stimulus {a1,a0,b1,b0} = idx, registered and stable for exactly HOLD_CYCLES cycles per vector.
  - hold increments every cycle.
  - In the cycle where hold==HOLD_CYCLES-1, r_in/g_in/b_in are compared to the golden value for idx.
  - On a mismatch at that edge: err_count increments. If fail_valid=0, then fail_vec<=idx and fail_valid<=1.
  - At that same edge: if idx<15, then idx increments and hold<=0. If idx==15, go to DONE.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - Stimulus returns to 0.
  - Results hold until rst or start.
  - start=1 in DONE behaves exactly as start in IDLE (immediate restart).
- start while busy=1 is ignored and has no effect on idx, hold or results.
- Latency:
  - First vector appears on the outputs the cycle after start is sampled.
  - done rises exactly 16*HOLD_CYCLES cycles after the start edge.
  - busy is high for exactly 16*HOLD_CYCLES cycles.
- err_count cannot overflow (maximum 16 fits in 5 bits); no saturation logic is needed.
- r_in/g_in/b_in are treated as synchronous to clk and are not sampled outside the compare cycle.

Test Plan:
- Correct DUT (golden model, HOLD_CYCLES=4), pulse start -> busy high 64 cycles, stimulus steps 0..15 every 4 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
- DUT with r and b swapped -> err_count=12 (all A!=B vectors), pass=0, fail_valid=1, fail_vec=4'b0001 (A=0, B=1 is the first A!=B vector).
- DUT with g stuck at 0 -> err_count=4, fail_vec=4'b0000.
- DUT with g stuck at 1 -> err_count=12, fail_vec=4'b0001.
- Assert rst at cycle 20 of a run -> next edge: all outputs 0, state IDLE. A new start gives a full 64-cycle run with correct results.
- start pulsed again at cycle 10 of a run -> ignored, done still at cycle 64. start in DONE -> results cleared on that edge, new run begins.
- HOLD_CYCLES=2 with a DUT whose outputs lag the inputs by 1 registered cycle -> pass=1. With a 2-cycle lag -> mismatches reported.
